// File: rtl/int_ctl_pkg.sv
// Shared definitions for the interrupt controller: NMI FSM state encoding and
// synchronizer depth.
package int_ctl_pkg;

    typedef enum logic [1:0] {
        NMI_IDLE = 2'd0,
        NMI_PEND = 2'd1,
        NMI_HELD = 2'd2
    } nmi_state_e;

    localparam int SYNC_DEPTH = 2;

    // Post-reset cycles during which NMI edge detection stays disabled. The
    // synchronizer resets to 0, so a level that was already high would
    // otherwise look like a fresh rising edge as it shifts through.
    function automatic int settle_cycles(input bit sync_en);
        return sync_en ? SYNC_DEPTH + 1 : 1;
    endfunction

endpackage

// File: rtl/int_ctl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async reset to 0.
module sync2
    import int_ctl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff <= '0;
        else       ff <= {ff[SYNC_DEPTH-2:0], d};
    end

    assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt controller: IRQ level qualification, NMI edge capture and
// acceptance handshake with the sequencer. INT_CTL_SYNC_EN adds input synchronizers.
module int_ctl
    import int_ctl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic nmi_in,
    input  logic sync,
    input  logic I,
    output logic irq,
    output logic nmi,
    output logic int_ack,
    output logic int_nmi
);

    logic irq_s;
    logic nmi_s;

`ifdef INT_CTL_SYNC_EN
    localparam int SETTLE = settle_cycles(1'b1);

    sync2 u_sync_irq (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .q     (irq_s)
    );

    sync2 u_sync_nmi (
        .clk   (clk),
        .reset (reset),
        .d     (nmi_in),
        .q     (nmi_s)
    );
`else
    localparam int SETTLE = settle_cycles(1'b0);

    assign irq_s = irq_in;
    assign nmi_s = nmi_in;
`endif

    localparam int CW = $clog2(SETTLE + 1);

    logic [CW-1:0] settle_cnt;
    logic          armed;
    logic          nmi_prev;
    logic          nmi_rise;
    nmi_state_e    state;
    nmi_state_e    state_nxt;

    assign armed    = (settle_cnt == CW'(SETTLE));
    assign nmi_rise = armed & nmi_s & ~nmi_prev;

    // Edge detection waits until the input path has refilled from reset, so
    // an NMI line already high at reset release never counts as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       settle_cnt <= '0;
        else if (!armed) settle_cnt <= settle_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) nmi_prev <= 1'b0;
        else       nmi_prev <= nmi_s;
    end

    // A rise arriving in the same cycle as acceptance keeps the FSM in PEND
    // so the second NMI is not swallowed.
    always_comb begin
        state_nxt = state;
        case (state)
            NMI_IDLE: if (nmi_rise)          state_nxt = NMI_PEND;
            NMI_PEND: if (sync && !nmi_rise) state_nxt = NMI_HELD;
            NMI_HELD: begin
                if (nmi_rise)    state_nxt = NMI_PEND;
                else if (!nmi_s) state_nxt = NMI_IDLE;
            end
            default:                         state_nxt = NMI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= NMI_IDLE;
        else       state <= state_nxt;
    end

    assign nmi = (state == NMI_PEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= irq_s;
    end

    // NMI wins over IRQ when both are present at the same decision cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_ack <= 1'b0;
            int_nmi <= 1'b0;
        end else begin
            int_ack <= sync & (nmi | (irq & ~I));
            int_nmi <= sync & nmi;
        end
    end

endmodule

// File: tb/tb_int_ctl.sv
// Self-checking bench for int_ctl: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the interrupt rules.
module tb_int_ctl;

`ifdef INT_CTL_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int SETTLE = D + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq_in = 1'b0, nmi_in = 1'b0, sync = 1'b0, I = 1'b1;
    logic irq, nmi, int_ack, int_nmi;

    int tests = 0;
    int fails = 0;

    int_ctl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .nmi_in  (nmi_in),
        .sync    (sync),
        .I       (I),
        .irq     (irq),
        .nmi     (nmi),
        .int_ack (int_ack),
        .int_nmi (int_nmi)
    );

    always #5 clk = ~clk;

    // Model: inputs seen D cycles late, NMI pending = unserviced rising edge,
    // acknowledge reported one cycle after the decision.
    int   mk;
    logic nh [0:2];
    logic ih [0:2];
    logic m_pend, m_irq, m_ack, m_inmi, m_prev;

    task automatic model_reset();
        mk = 0;
        for (int j = 0; j < 3; j++) begin nh[j] = 1'b0; ih[j] = 1'b0; end
        m_pend = 1'b0; m_irq = 1'b0; m_ack = 1'b0; m_inmi = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_step();
        logic ns, is, rise;
        nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = nmi_in;
        ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = irq_in;
        ns = (mk >= D) ? nh[D] : 1'b0;
        is = (mk >= D) ? ih[D] : 1'b0;
        rise = (mk >= SETTLE) && ns && !m_prev;
        m_ack  = sync && (m_pend || (m_irq && !I));
        m_inmi = sync && m_pend;
        m_pend = rise || (m_pend && !sync);
        m_irq  = is;
        m_prev = ns;
        mk++;
    endtask

    task automatic tick(input logic iv, input logic nv, input logic sv, input logic Iv,
                        input string name);
        irq_in = iv; nmi_in = nv; sync = sv; I = Iv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        tests++;
        if ({irq, nmi, int_ack, int_nmi} !== {m_irq, m_pend, m_ack, m_inmi}) begin
            fails++;
            $display("FAIL %s cycle %0d: irq/nmi/ack/int_nmi got %b expected %b",
                     name, mk, {irq, nmi, int_ack, int_nmi}, {m_irq, m_pend, m_ack, m_inmi});
        end
    endtask

    task automatic do_reset(input logic nv, input logic iv);
        @(negedge clk);
        irq_in = iv; nmi_in = nv; sync = 1'b0; I = 1'b1;
        reset = 1'b1;
        #1;
        tests++;
        if ({irq, nmi, int_ack, int_nmi} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs got %b expected 0000", {irq, nmi, int_ack, int_nmi});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, "reset_first");
        tests++;
        if (irq !== 1'b0 && D > 0) begin
            fails++;
            $display("FAIL irq_first_cycle got %b expected 0", irq);
        end else if (irq !== 1'b1 && D == 0) begin
            fails++;
            $display("FAIL irq_first_cycle got %b expected 1", irq);
        end
    endtask

    task automatic test_nmi_held();
        int acks = 0;
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 70; t++) begin
            tick(1'b0, (t >= 10 && t < 60), (t == 20), 1'b1, "nmi_held");
            if (t == 9 + D) begin
                tests++;
                if (nmi !== 1'b0) begin fails++; $display("FAIL nmi_early got %b expected 0", nmi); end
            end
            if (t == 10 + D) begin
                tests++;
                if (nmi !== 1'b1) begin fails++; $display("FAIL nmi_latency got %b expected 1", nmi); end
            end
            if (t == 19) begin
                tests++;
                if (nmi !== 1'b1) begin fails++; $display("FAIL nmi_before_sync got %b expected 1", nmi); end
            end
            if (t == 20) begin
                tests++;
                if ({int_ack, int_nmi, nmi} !== 3'b110) begin
                    fails++;
                    $display("FAIL nmi_accept ack/int_nmi/nmi got %b expected 110", {int_ack, int_nmi, nmi});
                end
            end
            if (int_ack) acks++;
        end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL nmi_held_count got %0d expected 1", acks); end
    endtask

    task automatic test_irq_mask();
        int acks = 0;
        int first = -1;
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            tick(1'b1, 1'b0, (t % 4 == 3), 1'b1, "irq_masked");
            if (int_ack) acks++;
        end
        tests++;
        if (acks != 0 || irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_masked acks %0d irq %b expected 0 and 1", acks, irq);
        end
        for (int t = 0; t < 12; t++) begin
            tick(1'b1, 1'b0, (t % 4 == 3), 1'b0, "irq_unmasked");
            if (int_ack && first < 0) first = t;
            if (t == 3) begin
                tests++;
                if ({int_ack, int_nmi} !== 2'b10) begin
                    fails++;
                    $display("FAIL irq_accept ack/int_nmi got %b expected 10", {int_ack, int_nmi});
                end
            end
        end
        tests++;
        if (first != 3) begin fails++; $display("FAIL irq_first_ack got %0d expected 3", first); end
    endtask

    task automatic test_priority();
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            tick(1'b1, (t >= 10), (t == 12 + D || t == 20 + D), 1'b0, "priority");
            if (t == 12 + D) begin
                tests++;
                if ({int_ack, int_nmi} !== 2'b11) begin
                    fails++;
                    $display("FAIL priority_nmi got %b expected 11", {int_ack, int_nmi});
                end
            end
            if (t == 20 + D) begin
                tests++;
                if ({int_ack, int_nmi} !== 2'b10) begin
                    fails++;
                    $display("FAIL priority_irq got %b expected 10", {int_ack, int_nmi});
                end
            end
        end
    endtask

    task automatic test_double_pulse();
        int acks = 0;
        int late_nmi = 0;
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 50; t++) begin
            tick(1'b0, ((t >= 10 && t < 13) || (t >= 15 && t < 45)), (t == 30), 1'b1, "double_pulse");
            if (int_ack) acks++;
            if (t >= 30 && nmi) late_nmi++;
        end
        tests++;
        if (acks != 1 || late_nmi != 0) begin
            fails++;
            $display("FAIL double_pulse acks %0d late_nmi %0d expected 1 and 0", acks, late_nmi);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            tick(1'b0, ((t >= 10 && t < 13) || (t >= 14 && t < 35)),
                 (t == 14 + D || t == 20 + D), 1'b1, "back_to_back");
            if (int_ack) acks++;
            if (t == 14 + D) begin
                tests++;
                if ({int_ack, int_nmi, nmi} !== 3'b111) begin
                    fails++;
                    $display("FAIL edge_at_accept ack/int_nmi/nmi got %b expected 111", {int_ack, int_nmi, nmi});
                end
            end
        end
        tests++;
        if (acks != 2) begin fails++; $display("FAIL back_to_back_count got %0d expected 2", acks); end
    endtask

    task automatic test_reset_nmi_high();
        int highs = 0;
        do_reset(1'b1, 1'b0);
        for (int t = 0; t < 100; t++) begin
            tick(1'b0, 1'b1, (t % 7 == 0), 1'b1, "nmi_high_at_reset");
            if (nmi || int_ack) highs++;
        end
        tests++;
        if (highs != 0) begin fails++; $display("FAIL nmi_high_at_reset got %0d events expected 0", highs); end
        for (int t = 0; t < 3; t++) tick(1'b0, 1'b0, 1'b0, 1'b1, "pend_setup");
        for (int t = 0; t < D + 2; t++) tick(1'b0, 1'b1, 1'b0, 1'b1, "pend_setup");
        tests++;
        if (nmi !== 1'b1) begin fails++; $display("FAIL pend_before_reset got %b expected 1", nmi); end
        reset = 1'b1;
        #1;
        tests++;
        if (nmi !== 1'b0) begin fails++; $display("FAIL reset_mid_pend got %b expected 0", nmi); end
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, 1'b1, 1'b1, "after_pend_reset");
    endtask

    task automatic test_random();
        logic iv = 1'b0;
        logic nv = 1'b0;
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 7) == 0) iv = ~iv;
            if ($urandom_range(0, 5) == 0) nv = ~nv;
            tick(iv, nv, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nmi_held();
        test_irq_mask();
        test_priority();
        test_double_pulse();
        test_back_to_back();
        test_reset_nmi_high();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
